// File: rtl/twitch_mem.sv
// Memory responder for twitchcore: host preload channel, core reset sequencing,
// and two registered read ports plus one write port while the core runs.
module twitch_mem #(
  parameter int ADDR_W   = 12,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_data,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_data,
  input  logic [31:0]       dw_data,
  input  logic              dw_en,
  input  logic              trap,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic [ADDR_W:0]   ld_count,
  output logic              core_resetn
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [3:0]        hold_q, hold_d;
  logic              rd_en_q, rd_en_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       i_raw_q, d_raw_q;

  logic              ld_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  assign ld_fire = ld_valid && (state_q == LOAD);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rd_en_q <= rd_en_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rd_en_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (ld_fire) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          // Filling the top word ends the image even without ld_last.
          if (ld_last || (&ptr_q)) begin
            state_d = HOLD;
            hold_d  = 4'(HOLD_CYC);
          end
        end
      end
      HOLD: begin
        hold_d = hold_q - 4'd1;
        if (hold_q == 4'd1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (trap) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end else begin
          rd_en_d = 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
        ptr_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    ld_ready    = (state_q == LOAD);
    core_resetn = (state_q == RUN);
    mem_we      = ld_fire || ((state_q == RUN) && dw_en);
    mem_waddr   = (state_q == LOAD) ? ptr_q : d_addr;
    mem_wdata   = (state_q == LOAD) ? ld_data : dw_data;
  end

  // Array kept reset-free so it maps to block RAM; reads return the pre-write word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    i_raw_q <= mem[i_addr];
    d_raw_q <= mem[d_addr];
  end

  assign i_data   = rd_en_q ? i_raw_q : 32'h0;
  assign d_data   = rd_en_q ? d_raw_q : 32'h0;
  assign ld_count = cnt_q;

endmodule

// File: tb/tb_twitch_mem.sv
// Self-checking bench for twitch_mem: load/hold/run sequencing, read-before-write,
// trap return, host throttling, async reset, and overflow on a small instance.
module tb_twitch_mem;

  localparam int AW = 12;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   i_data, d_data, dw_data, ld_data;
  logic          dw_en, trap, ld_valid, ld_ready, ld_last, core_resetn;
  logic [AW:0]   ld_count;

  logic [SW-1:0] s_i_addr, s_d_addr;
  logic [31:0]   s_i_data, s_d_data, s_ld_data;
  logic          s_ld_valid, s_ld_ready, s_ld_last, s_core_resetn;
  logic [SW:0]   s_ld_count;

  always #5 clk = ~clk;

  twitch_mem #(.ADDR_W(AW), .HOLD_CYC(2)) u_dut (
    .clk(clk), .reset(reset),
    .i_addr(i_addr), .i_data(i_data),
    .d_addr(d_addr), .d_data(d_data),
    .dw_data(dw_data), .dw_en(dw_en), .trap(trap),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_count(ld_count), .core_resetn(core_resetn)
  );

  twitch_mem #(.ADDR_W(SW), .HOLD_CYC(2)) u_small (
    .clk(clk), .reset(reset),
    .i_addr(s_i_addr), .i_data(s_i_data),
    .d_addr(s_d_addr), .d_data(s_d_data),
    .dw_data(32'h0), .dw_en(1'b0), .trap(1'b0),
    .ld_valid(s_ld_valid), .ld_ready(s_ld_ready), .ld_data(s_ld_data), .ld_last(s_ld_last),
    .ld_count(s_ld_count), .core_resetn(s_core_resetn)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model [2**AW];
  bit          known [2**AW];
  int          ptr_m = 0;

  typedef struct {
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [31:0]   i_exp;
    logic [31:0]   d_exp;
    bit            i_ok;
    bit            d_ok;
  } rd_t;
  rd_t sb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w, input logic last);
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    tick();
    model[ptr_m] = w;
    known[ptr_m] = 1'b1;
    ptr_m++;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 32'hBAD0_BAD0;
    $display("load word %08h last=%0d count=%0d", w, last, ld_count);
  endtask

  task automatic hold_release(input string tag);
    tick();
    check_eq({tag, "_hold_resetn"}, 64'(core_resetn), 64'd0);
    tick();
    check_eq({tag, "_release_resetn"}, 64'(core_resetn), 64'd1);
  endtask

  // Expected read results are queued at drive time and retired after the edge.
  task automatic run_cycle(input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic we, input logic [31:0] wd);
    rd_t e;
    i_addr  = ia;
    d_addr  = da;
    dw_en   = we;
    dw_data = wd;
    e.ia    = ia;
    e.da    = da;
    e.i_exp = model[ia];
    e.d_exp = model[da];
    e.i_ok  = known[ia];
    e.d_ok  = known[da];
    sb.push_back(e);
    if (we) begin
      model[da] = wd;
      known[da] = 1'b1;
    end
    tick();
    dw_en = 1'b0;
    e = sb.pop_front();
    if (e.i_ok) check_eq($sformatf("i_data[%0h]", e.ia), 64'(i_data), 64'(e.i_exp));
    if (e.d_ok) check_eq($sformatf("d_data[%0h]", e.da), 64'(d_data), 64'(e.d_exp));
    $display("run i[%03h]=%08h d[%03h]=%08h we=%0d", e.ia, i_data, e.da, d_data, we);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h00000013;
    prog[1] = 32'h00100093;
    prog[2] = 32'h00208113;
    prog[3] = 32'h0000006f;

    reset = 1'b1;
    i_addr = '0; d_addr = '0; dw_data = '0; dw_en = 1'b0; trap = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    s_i_addr = '0; s_d_addr = '0; s_ld_valid = 1'b0; s_ld_data = '0; s_ld_last = 1'b0;
    repeat (2) tick();
    check_eq("rst_ld_count", 64'(ld_count), 64'd0);
    check_eq("rst_core_resetn", 64'(core_resetn), 64'd0);
    check_eq("rst_ld_ready", 64'(ld_ready), 64'd1);
    check_eq("rst_i_data", 64'(i_data), 64'd0);
    check_eq("rst_d_data", 64'(d_data), 64'd0);
    reset = 1'b0;
    ptr_m = 0;

    // Basic program load and first fetch
    for (int k = 0; k < 4; k++) load_word(prog[k], k == 3);
    check_eq("load4_count", 64'(ld_count), 64'd4);
    check_eq("load4_ready", 64'(ld_ready), 64'd0);
    check_eq("load4_resetn", 64'(core_resetn), 64'd0);
    hold_release("load4");
    run_cycle(12'h1, 12'h2, 1'b0, 32'h0);
    run_cycle(12'h0, 12'h3, 1'b0, 32'h0);

    // Read-before-write on both ports
    run_cycle(12'h0, 12'h10, 1'b1, 32'hCAFEF00D);
    run_cycle(12'h10, 12'h10, 1'b1, 32'hDEADBEEF);
    run_cycle(12'h10, 12'h10, 1'b0, 32'h0);

    // Trap with a same-edge write
    trap = 1'b1; dw_en = 1'b1; d_addr = 12'h20; dw_data = 32'h12345678;
    model[12'h20] = 32'h12345678;
    known[12'h20] = 1'b1;
    tick();
    trap = 1'b0; dw_en = 1'b0;
    ptr_m = 0;
    $display("trap with write 0x20");
    check_eq("trap_resetn", 64'(core_resetn), 64'd0);
    check_eq("trap_ready", 64'(ld_ready), 64'd1);
    check_eq("trap_count", 64'(ld_count), 64'd0);
    check_eq("trap_i_data", 64'(i_data), 64'd0);
    check_eq("trap_d_data", 64'(d_data), 64'd0);

    // Throttled host stream; trap on idle cycles must be ignored in LOAD
    for (int k = 0; k < 6; k++) begin
      load_word(32'hA000_0000 + 32'(k) * 32'h111, k == 5);
      check_eq($sformatf("thr_count%0d", k), 64'(ld_count), 64'(k + 1));
      if (k < 5) begin
        trap = 1'b1;
        tick();
        trap = 1'b0;
        check_eq($sformatf("thr_idle_ready%0d", k), 64'(ld_ready), 64'd1);
      end
    end
    hold_release("thr");
    for (int k = 0; k < 6; k++) run_cycle(12'(k), 12'h20, 1'b0, 32'h0);
    run_cycle(12'h10, 12'h5, 1'b0, 32'h0);

    // Asynchronous reset while running
    #2 reset = 1'b1;
    #1;
    check_eq("runrst_resetn", 64'(core_resetn), 64'd0);
    check_eq("runrst_ready", 64'(ld_ready), 64'd1);
    check_eq("runrst_i_data", 64'(i_data), 64'd0);
    tick();
    reset = 1'b0;
    ptr_m = 0;

    // Reset mid-load, then a shorter reload
    load_word(32'h0000_0111, 1'b0);
    load_word(32'h0000_0222, 1'b0);
    load_word(32'h0000_0333, 1'b0);
    check_eq("midload_count", 64'(ld_count), 64'd3);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_count", 64'(ld_count), 64'd0);
    tick();
    reset = 1'b0;
    ptr_m = 0;
    load_word(32'h0000_0444, 1'b0);
    load_word(32'h0000_0555, 1'b1);
    check_eq("reload_count", 64'(ld_count), 64'd2);
    hold_release("reload");
    run_cycle(12'h0, 12'h1, 1'b0, 32'h0);
    run_cycle(12'h2, 12'h2, 1'b0, 32'h0);

    // Overflow on the 8-word instance
    for (int k = 0; k < 8; k++) begin
      s_ld_valid = 1'b1;
      s_ld_data  = 32'h5000 + 32'(k);
      tick();
      check_eq($sformatf("ovf_count%0d", k), 64'(s_ld_count), 64'(k + 1));
      $display("small load word %08h count=%0d", s_ld_data, s_ld_count);
    end
    check_eq("ovf_ready", 64'(s_ld_ready), 64'd0);
    check_eq("ovf_resetn", 64'(s_core_resetn), 64'd0);
    s_ld_data = 32'h99;
    tick();
    check_eq("ovf_9th_count", 64'(s_ld_count), 64'd8);
    check_eq("ovf_9th_resetn", 64'(s_core_resetn), 64'd0);
    tick();
    s_ld_valid = 1'b0;
    check_eq("ovf_release", 64'(s_core_resetn), 64'd1);
    for (int k = 0; k < 8; k++) begin
      s_i_addr = 3'(k);
      s_d_addr = 3'(7 - k);
      tick();
      check_eq($sformatf("ovf_i[%0d]", k), 64'(s_i_data), 64'(32'h5000 + 32'(k)));
      check_eq($sformatf("ovf_d[%0d]", 7 - k), 64'(s_d_data), 64'(32'h5000 + 32'(7 - k)));
      $display("small run i[%0d]=%08h d[%0d]=%08h", k, s_i_data, 7 - k, s_d_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
